// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: synchronizes and debounces PLL lock, then releases the
// core reset and, STAGE_GAP cycles later, the peripheral reset.
module reset_sequencer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEBOUNCE       = 8,
    parameter int unsigned STRETCH_CYCLES = 1024,
    parameter int unsigned STAGE_GAP      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       core_reset,
    output logic       periph_reset,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] lock_loss_count
);

    localparam int unsigned MaxA     = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
    localparam int unsigned MaxCount = (MaxA > DEBOUNCE) ? MaxA : DEBOUNCE;
    localparam int unsigned CntW     = $clog2(MaxCount + 1);

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StStretch  = 2'd1,
        StStage    = 2'd2,
        StRun      = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        deb_q, deb_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [7:0]             loss_q, loss_d;
    logic                   locked_s;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], pll_locked};
    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StWaitLock;
            sync_q  <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        deb_d   = '0;
        cnt_d   = '0;
        loss_d  = loss_q;
        unique case (state_q)
            StWaitLock: begin
                if (locked_s) begin
                    if (deb_q == CntW'(DEBOUNCE - 1)) begin
                        state_d = StStretch;
                    end else begin
                        deb_d = deb_q + CntW'(1);
                    end
                end
            end
            StStretch: begin
                if (cnt_q == CntW'(STRETCH_CYCLES - 1)) begin
                    state_d = StStage;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStage: begin
                if (cnt_q == CntW'(STAGE_GAP - 1)) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: state_d = StRun;
        endcase

        // Lock loss outranks a software request arriving in the same cycle.
        if (state_q != StWaitLock) begin
            if (!locked_s) begin
                state_d = StWaitLock;
                cnt_d   = '0;
                if (loss_q != 8'hFF) begin
                    loss_d = loss_q + 8'd1;
                end
            end else if (soft_reset_req) begin
                state_d = StStretch;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        core_reset   = 1'b1;
        periph_reset = 1'b1;
        ready        = 1'b0;
        unique case (state_q)
            StWaitLock, StStretch: begin
                core_reset   = 1'b1;
                periph_reset = 1'b1;
            end
            StStage: begin
                core_reset   = 1'b0;
                periph_reset = 1'b1;
            end
            StRun: begin
                core_reset   = 1'b0;
                periph_reset = 1'b0;
                ready        = 1'b1;
            end
        endcase
    end

    assign state           = state_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       core_reset;
    logic       periph_reset;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_loss_count;

    int cyc    = 0;
    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    exp_t sb[$];

    reset_sequencer #(
        .SYNC_STAGES   (2),
        .DEBOUNCE      (4),
        .STRETCH_CYCLES(16),
        .STAGE_GAP     (4)
    ) dut (
        .clock          (clk),
        .reset          (reset),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .core_reset     (core_reset),
        .periph_reset   (periph_reset),
        .ready          (ready),
        .state          (state),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expectation for the outputs seen after posedge number c.
    task automatic expect_at(input int c, input logic [1:0] st, input logic [7:0] cnt,
                             input string name);
        exp_t e;
        e.cyc  = c;
        e.st   = st;
        e.cnt  = cnt;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic exp_core, exp_per, exp_rdy;
                exp_core = (sb[i].st == 2'd0) || (sb[i].st == 2'd1);
                exp_per  = (sb[i].st != 2'd3);
                exp_rdy  = (sb[i].st == 2'd3);
                n_run++;
                if (state !== sb[i].st || core_reset !== exp_core || periph_reset !== exp_per ||
                    ready !== exp_rdy || lock_loss_count !== sb[i].cnt) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got st=%0d core=%b per=%b rdy=%b cnt=%0d, want st=%0d core=%b per=%b rdy=%b cnt=%0d",
                             sb[i].name, cyc, state, core_reset, periph_reset, ready,
                             lock_loss_count, sb[i].st, exp_core, exp_per, exp_rdy, sb[i].cnt);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_run++;
                n_fail++;
                $display("FAIL %s: expectation for cyc=%0d never sampled (now %0d)",
                         sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cyc=%0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   c0;
        int   c1;
        logic [7:0] exp_cnt;

        reset          = 1'b1;
        pll_locked     = 1'b0;
        soft_reset_req = 1'b0;

        // Power-up: reset 3 cycles, then lock.
        for (int k = 1; k <= 3; k++) expect_at(k, 2'd0, 8'd0, "reset_state");
        tick(3);
        reset      = 1'b0;
        pll_locked = 1'b1;
        c0         = cyc;
        expect_at(c0 + 5,  2'd0, 8'd0, "pwr_debounce");
        expect_at(c0 + 6,  2'd1, 8'd0, "pwr_stretch_entry");
        expect_at(c0 + 21, 2'd1, 8'd0, "pwr_core_held");
        expect_at(c0 + 22, 2'd2, 8'd0, "pwr_core_release");
        expect_at(c0 + 25, 2'd2, 8'd0, "pwr_periph_held");
        expect_at(c0 + 26, 2'd3, 8'd0, "pwr_run");
        tick(30);

        // Glitchy lock after a fresh reset: 3 high, 1 low, then high.
        reset      = 1'b1;
        pll_locked = 1'b0;
        expect_at(cyc + 2, 2'd0, 8'd0, "rerst_state");
        tick(2);
        reset = 1'b0;
        c0    = cyc;
        expect_at(c0 + 6,  2'd0, 8'd0, "glitch_no_stretch");
        expect_at(c0 + 9,  2'd0, 8'd0, "glitch_debounce");
        expect_at(c0 + 10, 2'd1, 8'd0, "glitch_stretch_entry");
        expect_at(c0 + 26, 2'd2, 8'd0, "glitch_stage");
        expect_at(c0 + 30, 2'd3, 8'd0, "glitch_run");
        pll_locked = 1'b1;
        tick(3);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(32);

        // Lock loss in RUN, then re-lock.
        c0 = cyc;
        pll_locked = 1'b0;
        expect_at(c0 + 2, 2'd3, 8'd0, "loss_still_run");
        expect_at(c0 + 3, 2'd0, 8'd1, "loss_wait_lock");
        tick(5);
        c0 = cyc;
        pll_locked = 1'b1;
        expect_at(c0 + 21, 2'd1, 8'd1, "relock_core_held");
        expect_at(c0 + 22, 2'd2, 8'd1, "relock_core_release");
        expect_at(c0 + 26, 2'd3, 8'd1, "relock_run");
        tick(30);

        // Soft reset in RUN.
        c0 = cyc;
        expect_at(c0 + 1,  2'd1, 8'd1, "soft_stretch");
        expect_at(c0 + 16, 2'd1, 8'd1, "soft_stretch_end");
        expect_at(c0 + 17, 2'd2, 8'd1, "soft_stage");
        expect_at(c0 + 20, 2'd2, 8'd1, "soft_stage_end");
        expect_at(c0 + 21, 2'd3, 8'd1, "soft_run");
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        tick(24);

        // Soft request in the same cycle locked_s drops: lock loss wins.
        c0 = cyc;
        pll_locked = 1'b0;
        tick(2);
        soft_reset_req = 1'b1;
        expect_at(c0 + 3, 2'd0, 8'd2, "simul_loss_wins");
        tick(1);
        soft_reset_req = 1'b0;
        tick(3);

        // 256 further lock losses: count saturates at 255.
        exp_cnt = 8'd2;
        for (int i = 0; i < 256; i++) begin
            c0 = cyc;
            pll_locked = 1'b1;
            expect_at(c0 + 6, 2'd1, exp_cnt, "sat_stretch");
            tick(7);
            c1 = cyc;
            pll_locked = 1'b0;
            if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
            expect_at(c1 + 3, 2'd0, exp_cnt, "sat_loss");
            tick(4);
        end

        // Reset at stretch cycle 8, then full rerun.
        c0 = cyc;
        pll_locked = 1'b1;
        expect_at(c0 + 14, 2'd1, 8'd255, "mid_stretch");
        tick(14);
        reset = 1'b1;
        expect_at(c0 + 15, 2'd0, 8'd0, "mid_stretch_reset");
        tick(1);
        reset = 1'b0;
        c1    = cyc;
        expect_at(c1 + 21, 2'd1, 8'd0, "rerun_core_held");
        expect_at(c1 + 22, 2'd2, 8'd0, "rerun_core_release");
        expect_at(c1 + 26, 2'd3, 8'd0, "rerun_run");
        tick(30);

        tick(2);
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
